// File: rtl/vga_text_terminal_pkg.sv
// Shared constants, types and helpers for the VGA text terminal.
// Holds the grid dimensions, the control-character codes, the cell and
// cursor types, the FSM state encoding and the glyph sanitiser.
package vga_text_terminal_pkg;

  localparam int unsigned VGA_BLOCK_HNUM = 100;
  localparam int unsigned VGA_BLOCK_VNUM = 37;
  localparam int unsigned GFX_ADDR_W     = 12;  // 100*37 = 3700 cells fit in 12 bits

  typedef logic [7:0]            Ascii_char_t;
  typedef logic [5:0]            Text_row_t;
  typedef logic [6:0]            Text_col_t;
  typedef logic [GFX_ADDR_W-1:0] Graphics_block_addr_t;

  localparam Ascii_char_t ASCII_SPACE = 8'h20;
  localparam Ascii_char_t ASCII_QMARK = 8'h3F;
  localparam Ascii_char_t ASCII_LF    = 8'h0A;
  localparam Ascii_char_t ASCII_CR    = 8'h0D;
  localparam Ascii_char_t ASCII_BS    = 8'h08;
  localparam Ascii_char_t ASCII_FF    = 8'h0C;

  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_IDLE    = 2'd1,
    ST_EMIT    = 2'd2,
    ST_CLR_ROW = 2'd3
  } term_state_e;

  // Anything the glyph ROM cannot draw becomes '?'; downstream subtracts 0x20.
  function automatic Ascii_char_t sanitize_char(input Ascii_char_t c);
    return ((c >= 8'h20) && (c <= 8'h7E)) ? c : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/vga_text_terminal_if.sv
// CPU-side character stream into the VGA text terminal.
// Signals: in_valid/in_char from the CPU, in_ready back from the terminal.
// Transfer happens on a clock edge where in_valid and in_ready are both high.
interface vga_text_terminal_if;
  import vga_text_terminal_pkg::*;

  logic        in_valid;
  Ascii_char_t in_char;
  logic        in_ready;

  modport master (output in_valid, output in_char, input  in_ready);
  modport slave  (input  in_valid, input  in_char, output in_ready);
endinterface

// File: rtl/text_char_fifo.sv
// Small synchronous character FIFO in front of the terminal FSM.
// Ports: clk_i, rst_ni (sync, active-low), push_i/din_i, pop_i/dout_o,
// empty_o (registered), ready_o (registered "not full", low during reset).
// Callers must only push when ready_o and only pop when !empty_o.
module text_char_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              ready_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, ready_q;

  // Pointer/occupancy next state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Flags are registered from the next occupancy so they carry no comb path.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      ready_q  <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/vga_text_terminal.sv
// Character-stream front end for vga_controller.
// Ports: clk_25M, rst (sync, active-low), cpu (char stream slave),
// write_op/bus_addr/bus_data (registered cell write), cursor_row/col,
// busy (high outside IDLE). Clears the screen after reset, then decodes
// one character per pop into cell writes and cursor moves.
module vga_text_terminal
  import vga_text_terminal_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HNUM       = VGA_BLOCK_HNUM,
  parameter int unsigned VNUM       = VGA_BLOCK_VNUM
) (
  input  logic                 clk_25M,
  input  logic                 rst,
  vga_text_terminal_if.slave   cpu,
  output logic                 write_op,
  output logic [31:0]          bus_addr,
  output logic [31:0]          bus_data,
  output logic [5:0]           cursor_row,
  output logic [6:0]           cursor_col,
  output logic                 busy
);

  localparam int unsigned ADDR_W    = GFX_ADDR_W;
  localparam int unsigned LAST_CELL = HNUM * VNUM - 1;

  term_state_e          state_q, state_d;
  Text_row_t            row_q, row_d;
  Text_col_t            col_q, col_d;
  Graphics_block_addr_t cnt_q, cnt_d;      // clear-sweep position
  Ascii_char_t          char_q, char_d;    // glyph pending for EMIT
  logic                 adv_q, adv_d;      // EMIT advances the cursor (not for BS)
  logic                 write_op_q, write_op_d;
  Graphics_block_addr_t addr_q, addr_d;
  Ascii_char_t          data_q, data_d;
  logic                 busy_q, busy_d;

  logic                 fifo_push, fifo_pop, fifo_empty, fifo_ready;
  Ascii_char_t          fifo_dout;
  Text_row_t            next_row;

  assign fifo_push = cpu.in_valid & fifo_ready;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

  text_char_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (8)
  ) u_fifo (
    .clk_i   (clk_25M),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .din_i   (cpu.in_char),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready)
  );

  function automatic Graphics_block_addr_t cell_addr(input Text_row_t r,
                                                     input Graphics_block_addr_t c);
    return Graphics_block_addr_t'(r) * Graphics_block_addr_t'(HNUM) + c;
  endfunction

  assign next_row = (row_q == Text_row_t'(VNUM - 1)) ? '0 : row_q + Text_row_t'(1);

  // Next-state, cursor and write-port logic.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    char_d     = char_q;
    adv_d      = adv_q;
    write_op_d = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      ST_CLR_ALL: begin
        write_op_d = 1'b1;
        addr_d     = cnt_q;
        data_d     = ASCII_SPACE;
        if (cnt_q == Graphics_block_addr_t'(LAST_CELL)) begin
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + Graphics_block_addr_t'(1);
        end
      end

      ST_IDLE: begin
        if (!fifo_empty) begin
          case (fifo_dout)
            ASCII_CR: col_d = '0;
            ASCII_LF: begin
              col_d   = '0;
              row_d   = next_row;
              cnt_d   = '0;
              state_d = ST_CLR_ROW;
            end
            ASCII_BS: begin
              // Step back first, then blank the cell now under the cursor.
              if (col_q != '0) begin
                col_d   = col_q - Text_col_t'(1);
                char_d  = ASCII_SPACE;
                adv_d   = 1'b0;
                state_d = ST_EMIT;
              end
            end
            ASCII_FF: begin
              cnt_d   = '0;
              state_d = ST_CLR_ALL;
            end
            default: begin
              char_d  = sanitize_char(fifo_dout);
              adv_d   = 1'b1;
              state_d = ST_EMIT;
            end
          endcase
        end
      end

      ST_EMIT: begin
        write_op_d = 1'b1;
        addr_d     = cell_addr(row_q, Graphics_block_addr_t'(col_q));
        data_d     = char_q;
        state_d    = ST_IDLE;
        if (adv_q) begin
          if (col_q == Text_col_t'(HNUM - 1)) begin
            col_d   = '0;
            row_d   = next_row;
            cnt_d   = '0;
            state_d = ST_CLR_ROW;
          end else begin
            col_d = col_q + Text_col_t'(1);
          end
        end
      end

      ST_CLR_ROW: begin
        write_op_d = 1'b1;
        addr_d     = cell_addr(row_q, cnt_q);
        data_d     = ASCII_SPACE;
        if (cnt_q == Graphics_block_addr_t'(HNUM - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + Graphics_block_addr_t'(1);
        end
      end

      default: state_d = ST_CLR_ALL;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_25M) begin
    if (!rst) begin
      state_q    <= ST_CLR_ALL;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      char_q     <= ASCII_SPACE;
      adv_q      <= 1'b0;
      write_op_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      char_q     <= char_d;
      adv_q      <= adv_d;
      write_op_q <= write_op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign cpu.in_ready = fifo_ready;
  assign write_op     = write_op_q;
  assign bus_addr     = 32'(addr_q);
  assign bus_data     = 32'(data_q);
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vga_text_terminal.sv
// Scoreboard bench for vga_text_terminal: stimulus queues expected cell
// writes, a negedge monitor pops and compares every write_op pulse.
module tb_vga_text_terminal;

  logic        clk_25M = 1'b0;
  logic        rst     = 1'b0;
  logic        write_op;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned exp_addr_q[$];
  int unsigned exp_data_q[$];

  vga_text_terminal_if cpu_if ();

  vga_text_terminal #(
    .FIFO_DEPTH (4),
    .HNUM       (100),
    .VNUM       (37)
  ) dut (
    .clk_25M    (clk_25M),
    .rst        (rst),
    .cpu        (cpu_if),
    .write_op   (write_op),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #20 clk_25M = ~clk_25M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input int unsigned addr, input int unsigned data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  task automatic expect_row_clear(input int unsigned row);
    for (int c = 0; c < 100; c++) expect_write(row * 100 + c, 32'h20);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk_25M) begin
    if (rst && write_op) begin
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h with nothing expected",
                 bus_addr, bus_data);
      end else begin
        int unsigned ea, ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (bus_addr !== ea || bus_data !== ed) begin
          n_errors++;
          $display("FAIL cell_write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                   bus_addr, bus_data, ea, ed);
        end
      end
    end
  end

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk_25M);
    cpu_if.in_valid = 1'b1;
    cpu_if.in_char  = c;
    while (!cpu_if.in_ready && n < 2000) begin
      @(negedge clk_25M);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready never rose for char 0x%0h", c);
    end
    @(posedge clk_25M);
    #1 cpu_if.in_valid = 1'b0;
  endtask

  // Wait for busy low on three consecutive samples, then confirm the scoreboard drained.
  task automatic wait_idle(input string name);
    int stable, n;
    stable = 0;
    n = 0;
    while (stable < 3 && n < 20000) begin
      @(negedge clk_25M);
      n++;
      stable = busy ? 0 : stable + 1;
    end
    if (n >= 20000) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: busy never settled low", name);
    end
    chk({name, "_drained"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic chk_cursor(input string name, input int unsigned r, input int unsigned c);
    chk({name, "_row"}, 32'(cursor_row), r);
    chk({name, "_col"}, 32'(cursor_col), c);
  endtask

  initial begin
    logic [7:0] burst [6];
    int         k, k_at_stall, cyc;
    logic       ready_now;

    cpu_if.in_valid = 1'b0;
    cpu_if.in_char  = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    chk("rst_write_op", 32'(write_op), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_data", bus_data, 32'd0);
    chk_cursor("rst_cursor", 0, 0);
    chk("rst_in_ready", 32'(cpu_if.in_ready), 32'd0);

    // Power-up screen clear: 3700 ascending space writes.
    for (int i = 0; i < 3700; i++) expect_write(i, 32'h20);
    rst = 1'b1;
    wait_idle("init_clear");
    chk_cursor("init_cursor", 0, 0);

    // 'A' with exact latency: accept at edge t, write visible after edge t+2.
    @(negedge clk_25M);
    chk("idle_in_ready", 32'(cpu_if.in_ready), 32'd1);
    cpu_if.in_valid = 1'b1;
    cpu_if.in_char  = 8'h41;
    expect_write(0, 32'h41);
    @(posedge clk_25M);
    #1 cpu_if.in_valid = 1'b0;
    chk("lat_t0_write_op", 32'(write_op), 32'd0);
    @(posedge clk_25M);
    #1 chk("lat_t1_write_op", 32'(write_op), 32'd0);
    @(posedge clk_25M);
    #1;
    chk("lat_t2_write_op", 32'(write_op), 32'd1);
    chk("lat_t2_addr", bus_addr, 32'd0);
    chk("lat_t2_data", bus_data, 32'h41);
    wait_idle("char_a");
    chk_cursor("after_a", 0, 1);

    // CR: column back to 0, no write.
    send_char(8'h0D);
    wait_idle("cr");
    chk_cursor("after_cr", 0, 0);

    // 'Z' then form feed: full clear, cursor home.
    expect_write(0, 32'h5A);
    send_char(8'h5A);
    wait_idle("char_z");
    chk_cursor("after_z", 0, 1);
    for (int i = 0; i < 3700; i++) expect_write(i, 32'h20);
    send_char(8'h0C);
    wait_idle("ff");
    chk_cursor("after_ff", 0, 0);

    // 100 'x' fill row 0, wrap clears row 1.
    for (int i = 0; i < 100; i++) expect_write(i, 32'h78);
    expect_row_clear(1);
    for (int i = 0; i < 100; i++) send_char(8'h78);
    wait_idle("row_wrap");
    chk_cursor("after_wrap", 1, 0);

    // 35 LFs to the last row, then "abcde".
    for (int r = 2; r <= 36; r++) begin
      expect_row_clear(r);
      send_char(8'h0A);
    end
    for (int i = 0; i < 5; i++) begin
      expect_write(3600 + i, 32'h61 + i);
      send_char(8'(8'h61 + i));
    end
    wait_idle("last_row");
    chk_cursor("at_36_5", 36, 5);

    // LF on the last row wraps to row 0 and blanks it.
    expect_row_clear(0);
    send_char(8'h0A);
    wait_idle("lf_wrap");
    chk_cursor("after_lf_wrap", 0, 0);

    // BS at column 0 is a no-op.
    expect_row_clear(1);
    expect_row_clear(2);
    send_char(8'h0A);
    send_char(8'h0A);
    wait_idle("to_row2");
    chk_cursor("at_2_0", 2, 0);
    send_char(8'h08);
    wait_idle("bs_col0");
    chk_cursor("bs_col0", 2, 0);

    // BS at column 3 blanks column 2.
    expect_write(200, 32'h61);
    expect_write(201, 32'h62);
    expect_write(202, 32'h63);
    send_char(8'h61);
    send_char(8'h62);
    send_char(8'h63);
    wait_idle("abc");
    chk_cursor("at_2_3", 2, 3);
    expect_write(202, 32'h20);
    send_char(8'h08);
    wait_idle("bs");
    chk_cursor("after_bs", 2, 2);

    // Back-pressure: 6 chars offered during a row clear; only 4 fit.
    expect_row_clear(3);
    burst = '{8'h41, 8'h42, 8'h01, 8'h43, 8'h44, 8'h45};
    expect_write(300, 32'h41);
    expect_write(301, 32'h42);
    expect_write(302, 32'h3F);
    expect_write(303, 32'h43);
    expect_write(304, 32'h44);
    expect_write(305, 32'h45);
    send_char(8'h0A);
    repeat (3) @(negedge clk_25M);
    k = 0;
    k_at_stall = -1;
    cyc = 0;
    while (k < 6 && cyc < 1000) begin
      @(negedge clk_25M);
      cyc++;
      cpu_if.in_valid = 1'b1;
      cpu_if.in_char  = burst[k];
      ready_now = cpu_if.in_ready;
      if (!ready_now && k_at_stall < 0) k_at_stall = k;
      @(posedge clk_25M);
      if (ready_now) begin
        k++;
        if (k == 4) begin
          #1 chk("full_in_ready", 32'(cpu_if.in_ready), 32'd0);
        end
      end
    end
    @(negedge clk_25M);
    cpu_if.in_valid = 1'b0;
    chk("accepted_before_stall", 32'(k_at_stall), 32'd4);
    chk("burst_all_accepted", 32'(k), 32'd6);
    wait_idle("burst");
    chk_cursor("after_burst", 3, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
